// File: rtl/mprj_io_cfg_loader.sv
// Streams per-pad config words from the register file into the GPIO serial chain,
// highest pad first and MSB first, then strobes serial_load so all pads switch together.
module mprj_io_cfg_loader #(
    parameter int IO_CNT   = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 4,
    localparam int AW = (IO_CNT > 1) ? $clog2(IO_CNT) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                abort,
    output logic [AW-1:0]       cfg_rd_addr,
    input  logic [CFG_BITS-1:0] cfg_rd_data,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load
);
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int DW = $clog2(CLK_DIV + 1);

    localparam logic [AW-1:0] IDX_TOP  = AW'(IO_CNT - 1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [BW-1:0] BIT_TOP  = BW'(CFG_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [DW-1:0] DIV_TOP  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, FINISH} state_t;

    state_t              state, state_n;
    logic                fetch_ph, fetch_ph_n;
    logic [DW-1:0]       div_cnt, div_n;
    logic [BW-1:0]       bit_cnt, bit_n;
    logic [AW-1:0]       idx, idx_n;
    logic [CFG_BITS-1:0] shreg, shreg_n;
    logic                take_abort;

    always_comb begin
        state_n    = state;
        fetch_ph_n = fetch_ph;
        div_n      = div_cnt;
        bit_n      = bit_cnt;
        idx_n      = idx;
        shreg_n    = shreg;
        take_abort = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    idx_n      = IDX_TOP;
                    fetch_ph_n = 1'b0;
                    state_n    = FETCH;
                end
            end
            FETCH: begin
                // phase 0 presents the address, phase 1 sees the registered read data
                if (!fetch_ph) begin
                    fetch_ph_n = 1'b1;
                end else begin
                    shreg_n = cfg_rd_data;
                    bit_n   = BIT_TOP;
                    div_n   = DIV_TOP;
                    state_n = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_cnt == '0) begin
                    div_n   = DIV_TOP;
                    state_n = SHIFT_HI;
                end else begin
                    div_n = div_cnt - DIV_ONE;
                end
            end
            SHIFT_HI: begin
                if (div_cnt != '0) begin
                    div_n = div_cnt - DIV_ONE;
                end else begin
                    div_n = DIV_TOP;
                    if (bit_cnt != '0) begin
                        shreg_n = shreg << 1;
                        bit_n   = bit_cnt - BIT_ONE;
                        state_n = SHIFT_LO;
                    end else if (idx != '0) begin
                        idx_n      = idx - IDX_ONE;
                        fetch_ph_n = 1'b0;
                        state_n    = FETCH;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            LOAD: begin
                if (div_cnt == '0) state_n = FINISH;
                else               div_n   = div_cnt - DIV_ONE;
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Once FINISH is reached the chain is already loaded, so abort no longer applies.
        if (abort && state != IDLE && state != FINISH) begin
            state_n    = IDLE;
            take_abort = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            fetch_ph     <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            idx          <= '0;
            shreg        <= '0;
            cfg_rd_addr  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
        end else begin
            state        <= state_n;
            fetch_ph     <= fetch_ph_n;
            div_cnt      <= div_n;
            bit_cnt      <= bit_n;
            idx          <= idx_n;
            shreg        <= shreg_n;
            cfg_rd_addr  <= idx_n;
            busy         <= (state_n != IDLE);
            done         <= (state == FINISH);
            aborted      <= take_abort;
            serial_clock <= (state_n == SHIFT_HI);
            serial_load  <= (state_n == LOAD);
            // data only moves while the chain clock is low, giving CLK_DIV cycles of setup/hold
            if (state_n == SHIFT_LO) serial_data <= shreg_n[CFG_BITS-1];
        end
    end
endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Randomized bench for mprj_io_cfg_loader: three parameterizations, a chain model per DUT,
// and expected images/streams/latencies derived directly from the pad words.
module tb_mprj_io_cfg_loader;
    localparam int B  = 13;
    localparam int NA = 38, DA = 4;
    localparam int NB = 2,  DB = 1;
    localparam int NC = 3,  DC = 3;
    localparam int LAT_A = NA * (2 + 2 * B * DA) + DA + 1;
    localparam int LAT_B = NB * (2 + 2 * B * DB) + DB + 1;
    localparam int LAT_C = NC * (2 + 2 * B * DC) + DC + 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT A: defaults ----------------
    logic start_a = 1'b0, abort_a = 1'b0;
    logic [5:0]   addr_a;
    logic [B-1:0] rdata_a;
    logic busy_a, done_a, aborted_a, sclk_a, sdat_a, sload_a;
    logic [B-1:0] mem_a [64];
    always @(posedge clk) rdata_a <= mem_a[addr_a];

    mprj_io_cfg_loader #(.IO_CNT(NA), .CFG_BITS(B), .CLK_DIV(DA)) u_dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .abort(abort_a),
        .cfg_rd_addr(addr_a), .cfg_rd_data(rdata_a), .busy(busy_a), .done(done_a),
        .aborted(aborted_a), .serial_clock(sclk_a), .serial_data(sdat_a), .serial_load(sload_a));

    int rises_a = 0, loads_a = 0, dones_a = 0, aborts_a = 0;
    logic [NA*B-1:0] chain_a = '0, latched_a = '0;
    logic psclk_a = 1'b0;
    always @(negedge clk) begin
        psclk_a <= sclk_a;
        if (sclk_a && !psclk_a) begin
            rises_a <= rises_a + 1;
            chain_a <= {chain_a[NA*B-2:0], sdat_a};
        end
        if (sload_a) begin
            loads_a   <= loads_a + 1;
            latched_a <= chain_a;
        end
        if (done_a)    dones_a  <= dones_a + 1;
        if (aborted_a) aborts_a <= aborts_a + 1;
    end

    // ---------------- DUT B: two pads, divide by 1 ----------------
    logic start_b = 1'b0, abort_b = 1'b0;
    logic [0:0]   addr_b;
    logic [B-1:0] rdata_b;
    logic busy_b, done_b, aborted_b, sclk_b, sdat_b, sload_b;
    logic [B-1:0] mem_b [2];
    always @(posedge clk) rdata_b <= mem_b[addr_b];

    mprj_io_cfg_loader #(.IO_CNT(NB), .CFG_BITS(B), .CLK_DIV(DB)) u_dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .abort(abort_b),
        .cfg_rd_addr(addr_b), .cfg_rd_data(rdata_b), .busy(busy_b), .done(done_b),
        .aborted(aborted_b), .serial_clock(sclk_b), .serial_data(sdat_b), .serial_load(sload_b));

    bit q_b[$];
    int loads_b = 0;
    logic psclk_b = 1'b0;
    always @(negedge clk) begin
        psclk_b <= sclk_b;
        if (sclk_b && !psclk_b) q_b.push_back(sdat_b);
        if (sload_b) loads_b <= loads_b + 1;
    end

    // ---------------- DUT C: three pads, divide by 3 ----------------
    logic start_c = 1'b0, abort_c = 1'b0;
    logic [1:0]   addr_c;
    logic [B-1:0] rdata_c;
    logic busy_c, done_c, aborted_c, sclk_c, sdat_c, sload_c;
    logic [B-1:0] mem_c [4];
    always @(posedge clk) rdata_c <= mem_c[addr_c];

    mprj_io_cfg_loader #(.IO_CNT(NC), .CFG_BITS(B), .CLK_DIV(DC)) u_dut_c (
        .clk(clk), .resetn(resetn), .start(start_c), .abort(abort_c),
        .cfg_rd_addr(addr_c), .cfg_rd_data(rdata_c), .busy(busy_c), .done(done_c),
        .aborted(aborted_c), .serial_clock(sclk_c), .serial_data(sdat_c), .serial_load(sload_c));

    int hi_run_c = 0, lo_run_c = 0, falls_c = 0, hi_bad_c = 0;
    int lo3_c = 0, lo5_c = 0, lo_bad_c = 0, stab_c = 0, min_stab_c = 1000, hold_bad_c = 0;
    logic [NC*B-1:0] chain_c = '0, latched_c = '0;
    logic psclk_c = 1'b0, psdat_c = 1'b0;
    always @(negedge clk) begin
        psclk_c <= sclk_c;
        psdat_c <= sdat_c;
        stab_c  <= (sdat_c == psdat_c) ? stab_c + 1 : 1;
        if (sdat_c != psdat_c && sclk_c && psclk_c) hold_bad_c <= hold_bad_c + 1;
        if (sclk_c && !psclk_c) begin
            chain_c <= {chain_c[NC*B-2:0], sdat_c};
            if (((sdat_c == psdat_c) ? stab_c : 0) < min_stab_c)
                min_stab_c <= (sdat_c == psdat_c) ? stab_c : 0;
            if (lo_run_c == DC)          lo3_c    <= lo3_c + 1;
            else if (lo_run_c == DC + 2) lo5_c    <= lo5_c + 1;
            else                         lo_bad_c <= lo_bad_c + 1;
            lo_run_c <= 0;
        end else if (!sclk_c) begin
            lo_run_c <= busy_c ? lo_run_c + 1 : 0;
        end
        if (sclk_c) begin
            hi_run_c <= hi_run_c + 1;
        end else if (psclk_c) begin
            falls_c <= falls_c + 1;
            if (hi_run_c != DC) hi_bad_c <= hi_bad_c + 1;
            hi_run_c <= 0;
        end
        if (sload_c) latched_c <= chain_c;
    end

    // ---------------- reference helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [NA*B-1:0] img_a();
        logic [NA*B-1:0] v;
        for (int p = 0; p < NA; p++) v[p*B +: B] = mem_a[p];
        return v;
    endfunction

    function automatic logic [NC*B-1:0] img_c();
        logic [NC*B-1:0] v;
        for (int p = 0; p < NC; p++) v[p*B +: B] = mem_c[p];
        return v;
    endfunction

    task automatic fill_a_random();
        for (int p = 0; p < NA; p++) mem_a[p] = 13'($urandom());
    endtask

    task automatic run_a(output int lat, output logic b0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        b0  = busy_a;
        lat = 0;
        while (!done_a && lat < LAT_A + 100) begin
            tick();
            lat++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        checks++;
        if ({busy_a, done_a, aborted_a, sclk_a, sdat_a, sload_a} !== 6'b0) begin
            errors++; $display("FAIL reset_outs_a got %b want 000000", {busy_a, done_a, aborted_a, sclk_a, sdat_a, sload_a});
        end
        checks++;
        if (addr_a !== 6'd0) begin errors++; $display("FAIL reset_addr_a got %0d want 0", addr_a); end
        checks++;
        if ({busy_b, sclk_b, sload_b, busy_c, sclk_c, sload_c} !== 6'b0) begin
            errors++; $display("FAIL reset_outs_bc got %b want 000000", {busy_b, sclk_b, sload_b, busy_c, sclk_c, sload_c});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_full_load();
        int lat, r0, l0, d0;
        logic b0;
        for (int p = 0; p < NA; p++) mem_a[p] = 13'h1A5A;
        r0 = rises_a; l0 = loads_a; d0 = dones_a;
        run_a(lat, b0);
        tick();
        checks++;
        if (b0 !== 1'b1) begin errors++; $display("FAIL busy_rise got %b want 1", b0); end
        checks++;
        if (lat !== LAT_A) begin errors++; $display("FAIL full_latency got %0d want %0d", lat, LAT_A); end
        checks++;
        if (rises_a - r0 !== NA * B) begin errors++; $display("FAIL full_rises got %0d want %0d", rises_a - r0, NA * B); end
        checks++;
        if (loads_a - l0 !== DA) begin errors++; $display("FAIL full_load_cycles got %0d want %0d", loads_a - l0, DA); end
        checks++;
        if (dones_a - d0 !== 1) begin errors++; $display("FAIL full_done_pulses got %0d want 1", dones_a - d0); end
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b want 0", busy_a); end
        for (int p = 0; p < NA; p++) begin
            checks++;
            if (latched_a[p*B +: B] !== 13'h1A5A) begin
                errors++; $display("FAIL full_slot%0d got %h want 1a5a", p, latched_a[p*B +: B]);
            end
        end
        fill_a_random();
        run_a(lat, b0);
        tick();
        checks++;
        if (lat !== LAT_A) begin errors++; $display("FAIL rand_latency got %0d want %0d", lat, LAT_A); end
        checks++;
        if (latched_a !== img_a()) begin errors++; $display("FAIL rand_image got %h want %h", latched_a, img_a()); end
    endtask

    task automatic test_abort();
        logic [NA*B-1:0] snap;
        int cut, l0, d0, a0;
        snap = latched_a;
        fill_a_random();
        for (int k = 0; k < 2; k++) begin
            cut = (k == 0) ? 500 : int'($urandom_range(0, LAT_A - DA - 6));
            l0 = loads_a; d0 = dones_a; a0 = aborts_a;
            start_a = 1'b1; tick(); start_a = 1'b0;
            repeat (cut) tick();
            abort_a = 1'b1; tick(); abort_a = 1'b0;
            checks++;
            if (aborted_a !== 1'b1) begin errors++; $display("FAIL abort%0d_pulse got %b want 1", k, aborted_a); end
            checks++;
            if (busy_a !== 1'b0) begin errors++; $display("FAIL abort%0d_busy got %b want 0", k, busy_a); end
            tick();
            checks++;
            if (aborted_a !== 1'b0) begin errors++; $display("FAIL abort%0d_pulse_len got %b want 0", k, aborted_a); end
            repeat (10) tick();
            checks++;
            if (aborts_a - a0 !== 1) begin errors++; $display("FAIL abort%0d_count got %0d want 1", k, aborts_a - a0); end
            checks++;
            if (loads_a - l0 !== 0 || dones_a - d0 !== 0) begin
                errors++; $display("FAIL abort%0d_no_load got loads %0d dones %0d want 0 0", k, loads_a - l0, dones_a - d0);
            end
            checks++;
            if (latched_a !== snap) begin errors++; $display("FAIL abort%0d_config got %h want %h", k, latched_a, snap); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, r0, d0, a0, again;
        fill_a_random();
        r0 = rises_a; d0 = dones_a;
        again = int'($urandom_range(5, LAT_A - 40));
        start_a = 1'b1; tick(); start_a = 1'b0;
        lat = 0;
        while (!done_a && lat < LAT_A + 100) begin
            tick();
            lat++;
            start_a = (lat == again);
        end
        start_a = 1'b0;
        repeat (20) tick();
        checks++;
        if (lat !== LAT_A) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT_A); end
        checks++;
        if (rises_a - r0 !== NA * B) begin errors++; $display("FAIL b2b_rises got %0d want %0d", rises_a - r0, NA * B); end
        checks++;
        if (dones_a - d0 !== 1 || busy_a !== 1'b0) begin
            errors++; $display("FAIL b2b_no_restart got dones %0d busy %b want 1 0", dones_a - d0, busy_a);
        end
        checks++;
        if (latched_a !== img_a()) begin errors++; $display("FAIL b2b_image got %h want %h", latched_a, img_a()); end
        r0 = rises_a; a0 = aborts_a;
        start_a = 1'b1; abort_a = 1'b1; tick(); start_a = 1'b0; abort_a = 1'b0;
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL start_abort_busy got %b want 0", busy_a); end
        repeat (20) tick();
        checks++;
        if (rises_a !== r0 || aborts_a !== a0) begin
            errors++; $display("FAIL start_abort_idle got rises %0d aborts %0d want %0d %0d", rises_a, aborts_a, r0, a0);
        end
    endtask

    task automatic test_reset_mid();
        int n, lat, d0, a0;
        logic b0;
        fill_a_random();
        d0 = dones_a; a0 = aborts_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        n = 0;
        while (!sclk_a && n < 200) begin tick(); n++; end
        checks++;
        if (sclk_a !== 1'b1) begin errors++; $display("FAIL rstmid_reach_hi got %b want 1", sclk_a); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({sclk_a, sload_a, busy_a} !== 3'b000) begin
            errors++; $display("FAIL rstmid_async got %b want 000", {sclk_a, sload_a, busy_a});
        end
        tick();
        resetn = 1'b1;
        repeat (5) tick();
        checks++;
        if (dones_a !== d0 || aborts_a !== a0) begin
            errors++; $display("FAIL rstmid_no_pulse got dones %0d aborts %0d want %0d %0d", dones_a, aborts_a, d0, a0);
        end
        fill_a_random();
        run_a(lat, b0);
        tick();
        checks++;
        if (lat !== LAT_A) begin errors++; $display("FAIL rstmid_relaunch_lat got %0d want %0d", lat, LAT_A); end
        checks++;
        if (latched_a !== img_a()) begin errors++; $display("FAIL rstmid_image got %h want %h", latched_a, img_a()); end
    endtask

    task automatic test_stream();
        bit exp[$];
        int qs, n, l0;
        for (int round = 0; round < 2; round++) begin
            if (round == 0) begin
                mem_b[0] = 13'h0001;
                mem_b[1] = 13'h1000;
            end else begin
                mem_b[0] = 13'($urandom());
                mem_b[1] = 13'($urandom());
            end
            exp.delete();
            for (int w = NB - 1; w >= 0; w--)
                for (int b = B - 1; b >= 0; b--) exp.push_back(mem_b[w][b]);
            qs = q_b.size(); l0 = loads_b;
            start_b = 1'b1; tick(); start_b = 1'b0;
            n = 0;
            while (!done_b && n < LAT_B + 50) begin tick(); n++; end
            tick();
            checks++;
            if (n !== LAT_B) begin errors++; $display("FAIL stream%0d_latency got %0d want %0d", round, n, LAT_B); end
            checks++;
            if (q_b.size() - qs !== NB * B) begin
                errors++; $display("FAIL stream%0d_len got %0d want %0d", round, q_b.size() - qs, NB * B);
            end else begin
                for (int i = 0; i < NB * B; i++) begin
                    checks++;
                    if (q_b[qs+i] !== exp[i]) begin
                        errors++; $display("FAIL stream%0d_bit%0d got %b want %b", round, i, q_b[qs+i], exp[i]);
                    end
                end
            end
            checks++;
            if (loads_b - l0 !== DB) begin errors++; $display("FAIL stream%0d_load_len got %0d want %0d", round, loads_b - l0, DB); end
        end
    endtask

    task automatic test_clkdiv3();
        int n, f0, hb0, l30, l50, lb0, hd0;
        for (int p = 0; p < NC; p++) mem_c[p] = 13'($urandom());
        f0 = falls_c; hb0 = hi_bad_c; l30 = lo3_c; l50 = lo5_c; lb0 = lo_bad_c; hd0 = hold_bad_c;
        start_c = 1'b1; tick(); start_c = 1'b0;
        n = 0;
        while (!done_c && n < LAT_C + 50) begin tick(); n++; end
        tick();
        checks++;
        if (n !== LAT_C) begin errors++; $display("FAIL div3_latency got %0d want %0d", n, LAT_C); end
        checks++;
        if (falls_c - f0 !== NC * B || hi_bad_c - hb0 !== 0) begin
            errors++; $display("FAIL div3_high_phase got highs %0d bad %0d want %0d 0", falls_c - f0, hi_bad_c - hb0, NC * B);
        end
        checks++;
        if (lo3_c - l30 !== NC * (B - 1) || lo5_c - l50 !== NC || lo_bad_c - lb0 !== 0) begin
            errors++; $display("FAIL div3_low_phase got lo3 %0d lo5 %0d bad %0d want %0d %0d 0",
                               lo3_c - l30, lo5_c - l50, lo_bad_c - lb0, NC * (B - 1), NC);
        end
        checks++;
        if (min_stab_c < DC) begin errors++; $display("FAIL div3_setup got %0d want >= %0d", min_stab_c, DC); end
        checks++;
        if (hold_bad_c - hd0 !== 0) begin errors++; $display("FAIL div3_hold got %0d want 0", hold_bad_c - hd0); end
        checks++;
        if (latched_c !== img_c()) begin errors++; $display("FAIL div3_image got %h want %h", latched_c, img_c()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem_a[i] = '0;
        mem_b[0] = '0; mem_b[1] = '0;
        for (int i = 0; i < 4; i++) mem_c[i] = '0;
        test_reset();
        test_full_load();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_stream();
        test_clkdiv3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
